// File: rtl/fetch.sv
// fetch: instruction fetch stage feeding decode.
//   Holds the PC and keeps at most one word read in flight to instruction
//   memory. The returned word and its PC are held for decode behind a
//   valid/ready handshake. A redirect from execute reloads the PC. It also
//   kills any fetch that is in flight or held.
//
// Ports
//   clk, reset                 single clock; synchronous active-high reset
//   imem_req_valid/ready       read request handshake, imem_addr = pc
//   imem_resp_valid, rdata     one in-order response per accepted request
//   redirect, redirect_pc      PC reload from execute; kills the current fetch
//   inst_valid/ready           handshake to decode, carrying inst and inst_pc
//   fault                      sticky misaligned-redirect flag
//
// Configuration
//   FETCH_MISALIGN_CHECK_EN    when defined, a redirect to a non word-aligned
//                              PC parks the stage in FAULT until reset. When
//                              undefined, redirect_pc[1:0] is ignored and
//                              fault is tied low.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, FAULT} state_t;

  // Word delivered to decode together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } held_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  held_t       held_q, held_d;
  logic [31:0] tgt;      // redirect target as it will be loaded into pc
  logic        bad_tgt;  // redirect to a misaligned target

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign tgt     = redirect_pc;
  assign bad_tgt = redirect & (redirect_pc[1:0] != 2'b00);

  // Sticky: set on the first misaligned redirect and cleared only by reset.
  assign fault_d = fault_q | ((state_q != FAULT) & bad_tgt);
  assign fault   = fault_q;

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`else
  // The low two bits are dropped, so every target is word aligned.
  assign tgt     = redirect_pc & ~32'h3;
  assign bad_tgt = 1'b0;
  assign fault   = 1'b0;
`endif

  // A redirect suppresses both handshakes in the cycle it is seen. This is
  // why a held instruction is never consumed alongside a redirect.
  assign imem_req_valid = (state_q == REQ) & ~redirect & ~reset;
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == HOLD) & ~redirect & ~reset;
  assign inst           = held_q.word;
  assign inst_pc        = held_q.pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    held_d  = held_q;
    if ((state_q != FAULT) && bad_tgt) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        REQ: begin
          // REQ never samples imem_resp_valid. A response still owed from
          // before a reset is therefore dropped without any effect.
          if (redirect)                             pc_d    = tgt;
          else if (imem_req_valid && imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (redirect) begin
            // If the response arrives in this same cycle it is the killed
            // one, so there is nothing left to drain.
            pc_d    = tgt;
            state_d = imem_resp_valid ? REQ : DROP;
          end else if (imem_resp_valid) begin
            held_d  = '{word: imem_rdata, pc: pc_q};
            pc_d    = pc_q + 32'd4;  // wraps modulo 2^32
            state_d = HOLD;
          end
        end
        DROP: begin
          // Waiting for the response of a killed request. Later redirects
          // only update the target.
          if (redirect)        pc_d    = tgt;
          if (imem_resp_valid) state_d = REQ;
        end
        HOLD: begin
          if (redirect) begin
            pc_d    = tgt;
            state_d = REQ;
          end else if (inst_ready) begin
            state_d = REQ;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      held_q  <= held_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch. A cycle-based driver models a single-outstanding
// instruction memory with configurable latency. The memory accepts a request
// only while the bench expects one. Expected fetch addresses and expected
// delivered {pc, word} pairs are queued when a scenario is set up. They are
// popped and compared on every accepted request and every consumed
// instruction.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_inst_t;

  typedef struct {
    logic [31:0] start;
    int          lat;
    int          n;
    logic [31:0] last_pc;
    int          cycles;
  } vec_t;

  logic [31:0] exp_addr_q[$];
  exp_inst_t   exp_inst_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // memory model state
  int          lat = 1;
  bit          mem_rdy_en = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic [31:0] last_pc = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(logic [31:0] a, bit delivered);
    exp_inst_t e;
    exp_addr_q.push_back(a);
    if (delivered) begin
      e.pc   = a;
      e.word = mem_word(a);
      exp_inst_q.push_back(e);
    end
  endtask

  // One clock: entered at a negedge with the inputs set, returns at the next negedge.
  task automatic cycle();
    bit          acc;
    logic [31:0] acc_addr;
    logic [31:0] ea;
    exp_inst_t   ei;
    imem_resp_valid = pend && (pend_cnt == 0);
    imem_rdata      = imem_resp_valid ? mem_word(pend_addr) : 32'h0;
    imem_req_ready  = mem_rdy_en && (exp_addr_q.size() != 0);
    #1;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    if (acc) begin
      ea = exp_addr_q.pop_front();
      chk("fetch_addr", imem_addr, ea);
    end
    if (inst_valid && inst_ready) begin
      if (exp_inst_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h, none expected", inst_pc);
      end else begin
        ei = exp_inst_q.pop_front();
        chk("inst_pc", inst_pc, ei.pc);
        chk("inst", inst, ei.word);
      end
      last_pc = inst_pc;
    end
    @(posedge clk);
    if (imem_resp_valid) pend = 1'b0;
    else if (pend)       pend_cnt--;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic redir(logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    cycle();
    redirect    = 1'b0;
    redirect_pc = '0;
  endtask

  task automatic drain(string name);
    int c = 0;
    while ((exp_inst_q.size() != 0 || exp_addr_q.size() != 0) && c < 100) begin
      cycle();
      c++;
    end
    chk(name, 32'(exp_inst_q.size() + exp_addr_q.size()), 32'd0);
  endtask

  task automatic wait_acc(string name, int left);
    int c = 0;
    while (exp_addr_q.size() > left && c < 50) begin
      cycle();
      c++;
    end
    chk(name, 32'(exp_addr_q.size()), 32'(left));
  endtask

  initial begin
    vec_t        vecs[4];
    int          cyc;
    logic [31:0] a;

    vecs[0] = '{start: 32'h0000_1000, lat: 1, n: 4, last_pc: 32'h0000_100C, cycles: 12};
    vecs[1] = '{start: 32'h0000_2000, lat: 3, n: 3, last_pc: 32'h0000_2008, cycles: 15};
    vecs[2] = '{start: 32'hFFFF_FFF8, lat: 1, n: 3, last_pc: 32'h0000_0000, cycles: 9};
    vecs[3] = '{start: 32'h0000_0040, lat: 2, n: 2, last_pc: 32'h0000_0044, cycles: 8};

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = '0;

    // Reset state, then a plain fetch stream from RESET_PC.
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 3; i++) expect_fetch(RST_PC + 32'(4 * i), 1'b1);
    cycle();
    reset = 1'b0;
    cyc = 0;
    while (exp_inst_q.size() != 0 && cyc < 100) begin
      cycle();
      cyc++;
    end
    chk("rst_stream_cycles", 32'(cyc), 32'd9);

    // Straight-line streams of different lengths and latencies.
    for (int v = 0; v < 4; v++) begin
      lat = vecs[v].lat;
      redir(vecs[v].start);
      for (int i = 0; i < vecs[v].n; i++) begin
        a = vecs[v].start + 32'(4 * i);
        expect_fetch(a, 1'b1);
      end
      cyc = 0;
      while (exp_inst_q.size() != 0 && cyc < 200) begin
        cycle();
        cyc++;
      end
      chk("vec_cycles", 32'(cyc), 32'(vecs[v].cycles));
      chk("vec_last_pc", last_pc, vecs[v].last_pc);
    end

    // Decode stalls for 5 cycles: the held instruction stays stable.
    lat = 1;
    redir(32'h500);
    inst_ready = 1'b0;
    expect_fetch(32'h500, 1'b1);
    expect_fetch(32'h504, 1'b1);
    cyc = 0;
    while (!inst_valid && cyc < 10) begin
      cycle();
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, mem_word(32'h500));
      chk("stall_inst_pc", inst_pc, 32'h500);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      cycle();
    end
    inst_ready = 1'b1;
    drain("stall_drain");

    // Redirect while waiting; the response arrives 3 cycles later and is dropped.
    lat = 4;
    redir(32'h600);
    expect_fetch(32'h600, 1'b0);
    expect_fetch(32'h200, 1'b1);
    wait_acc("wait_acc_600", 1);
    redir(32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drop_inst_valid", 32'(inst_valid), 32'd0);
      chk("drop_no_req", 32'(imem_req_valid), 32'd0);
      cycle();
    end
    drain("drop_drain");

    // Redirect meets the response in WAIT; a later redirect in HOLD beats inst_ready.
    lat = 1;
    inst_ready = 1'b0;
    redir(32'h700);
    expect_fetch(32'h700, 1'b0);
    expect_fetch(32'h300, 1'b0);
    expect_fetch(32'h300, 1'b1);
    wait_acc("wait_acc_700", 2);
    redir(32'h300);
    wait_acc("wait_acc_300", 1);
    cycle();
    #1;
    chk("hold_valid", 32'(inst_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    inst_ready  = 1'b1;
    #1;
    chk("redir_kills_valid", 32'(inst_valid), 32'd0);
    cycle();
    redirect = 1'b0;
    drain("redir_hold_drain");

    // Reset while waiting: the stale response must not reach decode.
    lat = 3;
    redir(32'h800);
    expect_fetch(32'h800, 1'b0);
    wait_acc("wait_acc_800", 0);
    reset      = 1'b1;
    mem_rdy_en = 1'b0;
    cycle();
    reset = 1'b0;
    expect_fetch(RST_PC, 1'b1);
    cyc = 0;
    while (pend && cyc < 10) begin
      #1;
      chk("stale_inst_valid", 32'(inst_valid), 32'd0);
      cycle();
      cyc++;
    end
    mem_rdy_en = 1'b1;
    drain("reset_drain");

    // Misaligned redirect.
    lat = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
    redir(32'h202);
    chk("fault_set", 32'(fault), 32'd1);
    expect_fetch(32'h400, 1'b0);
    for (int i = 0; i < 4; i++) begin
      redirect    = i[0];
      redirect_pc = 32'h400;
      #1;
      chk("fault_no_req", 32'(imem_req_valid), 32'd0);
      chk("fault_no_inst", 32'(inst_valid), 32'd0);
      chk("fault_sticky", 32'(fault), 32'd1);
      cycle();
    end
    redirect = 1'b0;
    chk("fault_req_pending", 32'(exp_addr_q.size()), 32'd1);
    void'(exp_addr_q.pop_front());
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("fault_cleared", 32'(fault), 32'd0);
    expect_fetch(RST_PC, 1'b1);
    drain("fault_recover_drain");
`else
    expect_fetch(32'h200, 1'b1);
    redir(32'h202);
    chk("no_fault", 32'(fault), 32'd0);
    drain("misalign_drain");
    chk("misalign_pc", last_pc, 32'h200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
